// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding and
// the default word/address sizes inherited from the core-wide defines.
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef MEM_SPACE
`define MEM_SPACE 8
`endif

package imem_load_ctrl_pkg;

  localparam int IMEM_ISIZE     = `ISIZE;
  localparam int IMEM_MEM_SPACE = `MEM_SPACE;

  typedef enum logic [2:0] {
    IMEM_LD_IDLE = 3'd0,
    IMEM_LD_HI   = 3'd1,
    IMEM_LD_LO   = 3'd2,
    IMEM_LD_WR   = 3'd3,
    IMEM_LD_CLR  = 3'd4,
    IMEM_LD_RUN  = 3'd5
  } imem_ld_state_t;

endpackage

// File: rtl/imem_load_ctrl.sv
// Boot-load controller: assembles big-endian byte pairs into instruction words,
// writes them from address 0, zero-fills the rest, then hands memory to fetch.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int ADDR_W = IMEM_MEM_SPACE,
  parameter int ISIZE  = IMEM_ISIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [ISIZE-1:0]  mem_wdata,
  output logic              cpu_stall,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0]   FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W + 1)'(1);

  imem_ld_state_t    state;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   n_words;
  logic [ISIZE-1:0]  wdata;
  logic [ADDR_W:0]   next_count;
  logic              loading;

  assign next_count = count + COUNT_ONE;

  // A length of zero encodes a full-memory load, hence the extra count bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IMEM_LD_IDLE;
      waddr   <= '0;
      count   <= '0;
      n_words <= '0;
      wdata   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IMEM_LD_IDLE, IMEM_LD_RUN: begin
          if (start) begin
            n_words <= (len == '0) ? FULL_COUNT : {1'b0, len};
            waddr   <= '0;
            count   <= '0;
            state   <= IMEM_LD_HI;
          end
        end
        IMEM_LD_HI: begin
          if (byte_valid) begin
            wdata[ISIZE-1 -: 8] <= byte_data;
            state               <= IMEM_LD_LO;
          end
        end
        IMEM_LD_LO: begin
          if (byte_valid) begin
            wdata[7:0] <= byte_data;
            state      <= IMEM_LD_WR;
          end
        end
        IMEM_LD_WR: begin
          waddr <= waddr + ADDR_ONE;
          count <= next_count;
          if (next_count == n_words) begin
            if (n_words == FULL_COUNT) begin
              state <= IMEM_LD_RUN;
              done  <= 1'b1;
            end else begin
              state <= IMEM_LD_CLR;
            end
          end else begin
            state <= IMEM_LD_HI;
          end
        end
        IMEM_LD_CLR: begin
          waddr <= waddr + ADDR_ONE;
          if (waddr == LAST_ADDR) begin
            state <= IMEM_LD_RUN;
            done  <= 1'b1;
          end
        end
        default: state <= IMEM_LD_IDLE;
      endcase
    end
  end

  // Everything except mem_addr is a pure decode of the registered state, so
  // byte_ready never depends on byte_valid.
  always_comb begin
    loading    = (state == IMEM_LD_HI) || (state == IMEM_LD_LO) ||
                 (state == IMEM_LD_WR) || (state == IMEM_LD_CLR);
    byte_ready = (state == IMEM_LD_HI) || (state == IMEM_LD_LO);
    busy       = loading;
    cpu_stall  = (state != IMEM_LD_RUN);
    mem_we     = (state == IMEM_LD_WR) || (state == IMEM_LD_CLR);
    mem_wdata  = (state == IMEM_LD_WR) ? wdata : '0;
    mem_addr   = loading ? waddr : fetch_addr;
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl (ADDR_W=4): random byte streams are
// compared against the memory image the load rules predict.
module tb_imem_load_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] len;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [AW-1:0] fetch_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [15:0]   mem_wdata;
  logic          cpu_stall;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  logic [7:0]  byte_q[$];
  logic [15:0] mem_obs[DEPTH];

  imem_load_ctrl #(.ADDR_W(AW), .ISIZE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .fetch_addr (fetch_addr),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .cpu_stall  (cpu_stall),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_stall"}, 32'(cpu_stall), 32'd1);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check_output({tag, "_we"}, 32'(mem_we), 32'd0);
    check_output({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check_output({tag, "_done"}, 32'(done), 32'd0);
    check_output({tag, "_addr"}, 32'(mem_addr), 32'(fetch_addr));
  endtask

  // Drives one complete load from byte_q and checks the resulting memory image.
  // Observations happen on falling edges, one half-cycle after each state change.
  task automatic apply_stimulus(input logic [AW-1:0] len_in, input bit gappy,
                                input bit start_mid, input string tag);
    logic [7:0]  src[$];
    logic [15:0] exp_mem[DEPTH];
    int          n_eff;
    int          cyc;
    int          done_cyc;
    int          wr_cnt;
    int          ready_in_wr;
    bit          finished;

    src   = byte_q;
    n_eff = (len_in == 0) ? DEPTH : int'(len_in);
    for (int a = 0; a < DEPTH; a++) begin
      exp_mem[a] = (a < n_eff) ? {src[2*a], src[2*a+1]} : 16'h0000;
      mem_obs[a] = 16'hxxxx;
    end
    wr_cnt      = 0;
    ready_in_wr = 0;
    done_cyc    = 0;
    finished    = 1'b0;
    cyc         = 0;

    @(negedge clk);
    start = 1'b1;
    len   = len_in;
    while (!finished && cyc < 300) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (cyc == 1) begin
        check_output({tag, "_stall_after_start"}, 32'(cpu_stall), 32'd1);
        check_output({tag, "_addr_after_start"}, 32'(mem_addr), 32'd0);
      end
      if (mem_we) begin
        mem_obs[mem_addr] = mem_wdata;
        wr_cnt++;
        if (byte_ready) ready_in_wr++;
      end
      if (done) begin
        finished = 1'b1;
        done_cyc = cyc;
        check_output({tag, "_stall_at_done"}, 32'(cpu_stall), 32'd0);
      end
      if (start_mid && cyc == 1) begin
        start = 1'b1;
        len   = 4'd9;
      end
      if (src.size() > 0 && !(gappy && cyc[0])) begin
        byte_valid = 1'b1;
        byte_data  = src[0];
        if (byte_ready) void'(src.pop_front());
      end else begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end
    end
    byte_valid = 1'b0;

    check_output({tag, "_finished"}, 32'(finished), 32'd1);
    check_output({tag, "_bytes_left"}, 32'(src.size()), 32'd0);
    check_output({tag, "_write_count"}, 32'(wr_cnt), 32'(DEPTH));
    check_output({tag, "_ready_during_write"}, 32'(ready_in_wr), 32'd0);
    for (int a = 0; a < DEPTH; a++)
      check_output($sformatf("%s_mem%0d", tag, a), 32'(mem_obs[a]), 32'(exp_mem[a]));
    // Three cycles per loaded word plus one per cleared word, seen one edge late.
    if (!gappy)
      check_output({tag, "_latency"}, 32'(done_cyc), 32'(3 * n_eff + (DEPTH - n_eff) + 1));

    fetch_addr = 4'($urandom_range(1, 15));
    @(negedge clk);
    check_output({tag, "_done_single"}, 32'(done), 32'd0);
    check_output({tag, "_run_stall"}, 32'(cpu_stall), 32'd0);
    check_output({tag, "_run_busy"}, 32'(busy), 32'd0);
    check_output({tag, "_run_we"}, 32'(mem_we), 32'd0);
    check_output({tag, "_run_addr"}, 32'(mem_addr), 32'(fetch_addr));
  endtask

  task automatic fill_random(input int n_bytes);
    byte_q = {};
    for (int i = 0; i < n_bytes; i++) byte_q.push_back(8'($urandom));
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    len        = '0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    fetch_addr = 4'h7;

    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    @(negedge clk);
    fetch_addr = 4'h3;
    #1;
    check_idle_outputs("idle");
    byte_valid = 1'b0;
    fetch_addr = 4'h7;

    byte_q = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    apply_stimulus(4'd3, 1'b0, 1'b0, "len3");

    fill_random(32);
    apply_stimulus(4'd0, 1'b0, 1'b0, "full");

    fill_random(4);
    apply_stimulus(4'd2, 1'b1, 1'b0, "gappy");

    fill_random(8);
    apply_stimulus(4'd4, 1'b0, 1'b1, "start_in_hi");

    // Abort a load while it sits in LO of the second word.
    @(negedge clk);
    start = 1'b1;
    len   = 4'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start      = 1'b0;
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
    end
    check_output("abort_in_lo_ready", 32'(byte_ready), 32'd1);
    check_output("abort_in_lo_addr", 32'(mem_addr), 32'd1);
    byte_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    rst = 1'b1;

    fill_random(4);
    apply_stimulus(4'd2, 1'b0, 1'b0, "reload");

    fill_random(2);
    apply_stimulus(4'd1, 1'b0, 1'b0, "restart_run");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Boot-load controller for the instruction memory of the 5-stage pipeline.
- After reset it holds the CPU stalled and accepts instruction words as a big-endian byte stream over a valid/ready handshake.
- It writes each word into the instruction memory write port, then zero-fills every unloaded location and releases the pipeline.
- It owns the instruction memory address mux: loader address while loading, fetch-stage PC otherwise.

## Interface
Parameters:
- ADDR_W, default `MEM_SPACE: instruction memory address width (depth 2**ADDR_W words).
- ISIZE, default `ISIZE (16): instruction word width. Fixed at 16; two bytes per word.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a load; sampled only in IDLE and RUN
- len  in  ADDR_W  words to load, sampled with start; 0 means 2**ADDR_W
- byte_valid  in  1  byte source has data
- byte_data  in  8  byte payload
- byte_ready  out  1  controller accepts a byte this cycle
- fetch_addr  in  ADDR_W  PC from fetch stage
- mem_addr  out  ADDR_W  instruction memory address
- mem_we  out  1  instruction memory write enable
- mem_wdata  out  ISIZE  instruction memory write data
- cpu_stall  out  1  holds the pipeline (PC and IF/ID) frozen
- busy  out  1  load or clear in progress
- done  out  1  one-cycle pulse when a load finishes

## Operation
- FSM states: IDLE, HI, LO, WR, CLR, RUN.
- IDLE (after reset):
  - cpu_stall=1.
  - start → latch len into word count N (ADDR_W+1 bits, 0 → 2**ADDR_W), clear waddr → HI.
- HI:
  - byte_ready=1.
  - On accept, capture byte into wdata[15:8] → LO.
- LO:
  - byte_ready=1.
  - On accept, capture byte into wdata[7:0] → WR.
- WR:
  - mem_we=1, mem_addr=waddr, mem_wdata=wdata.
  - Increment waddr and the loaded count.
  - If loaded count == N: go to CLR if N < 2**ADDR_W, else to RUN with done.
  - Otherwise go to HI.
- CLR:
  - mem_we=1, mem_wdata=0, mem_addr=waddr, one word per cycle.
  - Increment waddr.
  - After writing address 2**ADDR_W-1 → RUN with done.
- RUN:
  - cpu_stall=0, busy=0, mem_addr=fetch_addr, mem_we=0.
  - start → re-load exactly as from IDLE, with cpu_stall reasserted the next cycle.
- mem_addr equals waddr in HI/LO/WR/CLR, fetch_addr in IDLE/RUN.
- busy=1 in HI/LO/WR/CLR.
- cpu_stall=1 in every state except RUN.
- start is ignored while busy: no error, no restart.
- byte_valid outside HI/LO is ignored, and the byte is not consumed (byte_ready=0).
- waddr arithmetic is modulo 2**ADDR_W. No write ever targets an address ≥ 2**ADDR_W.

## Timing
- Reset values:
  - state IDLE; waddr=0; count=0; wdata=0.
  - byte_ready=0, mem_we=0, mem_wdata=0, mem_addr=fetch_addr.
  - cpu_stall=1, busy=0, done=0.
- Reset asserted mid-load aborts immediately. Partially written memory is left as-is and the controller returns to IDLE stalled.
- Handshake rules:
  - A byte transfers on a rising edge with byte_valid & byte_ready.
  - byte_ready depends only on state, never combinationally on byte_valid.
- Latencies:
  - Minimum 3 cycles per word (HI, LO, WR) with byte_valid held high.
  - Stalls in HI/LO extend the load indefinitely (no timeout).
  - Clear takes 2**ADDR_W − N cycles.
- done:
  - Registered; high the first cycle the state is RUN.
  - cpu_stall falls in the same cycle.
- Fetch reads:
  - The memory's registered read of fetch_addr is valid one cycle after RUN is entered.
  - The fetch stage must treat its first post-stall cycle as a bubble.
- All outputs except mem_addr (a mux on fetch_addr) are registered or decoded from state only.

## Structure
- Shared package/define file: state encoding constants (IMEM_LD_IDLE … IMEM_LD_RUN, 3 bits), plus existing `ISIZE and `MEM_SPACE.
- Single module, no sub-modules; the byte-pair assembly register is inline.
- The instruction memory gains a synchronous write port (we/wdata) fed from this block. Its file-based initialisation stays simulation-only.

## Test plan
All scenarios use ADDR_W=4 (16 words).
- Reset → cpu_stall=1, busy=0, byte_ready=0, mem_we=0; mem_addr tracks fetch_addr=4'h7.
- start, len=3, bytes 12 34 56 78 9A BC back-to-back:
  - writes 0x1234@0, 0x5678@1, 0x9ABC@2;
  - then zeros @3..@15 on 13 consecutive cycles;
  - done pulses once, cpu_stall falls; total 9+13 cycles after start.
- len=0, 32 bytes:
  - 16 words written at 0..15, no CLR cycles;
  - done follows the WR of address 15; waddr wraps to 0.
- Gappy source (byte_valid toggled every other cycle) with len=2:
  - identical memory contents and no bytes dropped or duplicated;
  - byte_ready never high in WR/CLR.
- start pulsed during HI:
  - ignored; load completes with the original len.
- rst low asserted in LO mid-load:
  - outputs take reset values asynchronously, and the next load from start rewrites from address 0.
- start in RUN with len=1:
  - cpu_stall rises the cycle after start and mem_addr switches to 0;
  - word written @0, zeros @1..@15, then done.
